// File: rtl/shadow_reg_pkg.sv
// Shared types and constants for the double-buffered control-register bank.
package shadow_reg_pkg;

   typedef enum logic [1:0] {
      CLEAN = 2'd0,
      DIRTY = 2'd1,
      HOLD  = 2'd2
   } state_e;

   localparam int MISSED_W = 8;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shadow_grace_timer.sv
// Down-counter bounding how long a lock-held commit may wait after vblank_start.
module shadow_grace_timer #(
   parameter int GRACE = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic dec_i,
   output logic expired_o
);

   localparam int CNT_W = (GRACE > 1) ? $clog2(GRACE) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CNT_W'(GRACE - 1);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/shadow_reg_bank.sv
// Shadow/active register bank; active copies update only at frame boundaries.
// Optional shadow readback port enabled by defining SHADOW_READBACK_EN.
module shadow_reg_bank
   import shadow_reg_pkg::*;
#(
   parameter int               N_REGS    = 4,
   parameter int               WIDTH     = 32,
   parameter int               GRACE     = 64,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              IDX_W     = idx_w(N_REGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic [WIDTH/8-1:0]    wr_be,
   input  logic                  wr_lock,
   input  logic                  vblank_start,
`ifdef SHADOW_READBACK_EN
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [WIDTH-1:0]      rd_data,
`endif
   output logic [N_REGS*WIDTH-1:0] active_regs,
   output logic [N_REGS-1:0]     dirty,
   output logic                  commit_pulse,
   output logic [MISSED_W-1:0]   missed_cnt,
   input  logic                  missed_clr
);

   localparam int NB = WIDTH / 8;

   state_e                state_q, state_d;
   logic [N_REGS-1:0]     dirty_q, dirty_d, wr_set;
   logic                  wr_hit;
   logic                  commit, miss, timer_load, timer_dec, timer_expired;
   logic                  commit_pulse_q;
   logic [MISSED_W-1:0]   missed_q, missed_d;
`ifdef SHADOW_READBACK_EN
   logic [N_REGS*WIDTH-1:0] shadow_flat;
`endif

   // Widened compare keeps the range check meaningful when N_REGS is a power of two.
   assign wr_hit = wr_en && ({1'b0, wr_idx} < (IDX_W+1)'(N_REGS));

   for (genvar gi = 0; gi < N_REGS; gi++) begin : g_reg
      logic             sel;
      logic [WIDTH-1:0] shadow_q, active_q;

      assign sel        = wr_hit && (wr_idx == IDX_W'(gi));
      assign wr_set[gi] = sel && (|wr_be);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            shadow_q <= RESET_VAL;
            active_q <= RESET_VAL;
         end else begin
            if (commit && dirty_q[gi]) begin
               active_q <= shadow_q;
            end
            if (sel) begin
               for (int b = 0; b < NB; b++) begin
                  if (wr_be[b]) begin
                     shadow_q[b*8 +: 8] <= wr_data[b*8 +: 8];
                  end
               end
            end
         end
      end

      assign active_regs[gi*WIDTH +: WIDTH] = active_q;
`ifdef SHADOW_READBACK_EN
      assign shadow_flat[gi*WIDTH +: WIDTH] = shadow_q;
`endif
   end

   // A write landing in the commit cycle re-arms its dirty bit.
   assign dirty_d = (dirty_q & ~{N_REGS{commit}}) | wr_set;

   always_comb begin
      missed_d = missed_q;
      if (missed_clr) begin
         missed_d = '0;
      end else if (miss && (missed_q != '1)) begin
         missed_d = missed_q + 1'b1;
      end
   end

   shadow_grace_timer #(
      .GRACE (GRACE)
   ) u_grace (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (timer_load),
      .dec_i     (timer_dec),
      .expired_o (timer_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= CLEAN;
         dirty_q        <= '0;
         commit_pulse_q <= 1'b0;
         missed_q       <= '0;
      end else begin
         state_q        <= state_d;
         dirty_q        <= dirty_d;
         commit_pulse_q <= commit;
         missed_q       <= missed_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CLEAN: begin
            if (|wr_set) state_d = DIRTY;
         end
         DIRTY: begin
            if (timer_load)  state_d = HOLD;
            else if (commit) state_d = (|wr_set) ? DIRTY : CLEAN;
         end
         HOLD: begin
            if (commit)    state_d = (|wr_set) ? DIRTY : CLEAN;
            else if (miss) state_d = DIRTY;
         end
         default: state_d = CLEAN;
      endcase
   end

   always_comb begin
      commit     = 1'b0;
      miss       = 1'b0;
      timer_load = 1'b0;
      timer_dec  = 1'b0;
      case (state_q)
         DIRTY: begin
            commit     = vblank_start && !wr_lock;
            timer_load = vblank_start && wr_lock;
         end
         HOLD: begin
            commit    = !wr_lock;
            miss      = wr_lock && timer_expired;
            timer_dec = 1'b1;
         end
         default: ;
      endcase
   end

   assign dirty        = dirty_q;
   assign commit_pulse = commit_pulse_q;
   assign missed_cnt   = missed_q;

`ifdef SHADOW_READBACK_EN
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= RESET_VAL;
      end else if ({1'b0, rd_idx} < (IDX_W+1)'(N_REGS)) begin
         rd_data_q <= shadow_flat[rd_idx*WIDTH +: WIDTH];
      end else begin
         rd_data_q <= '0;
      end
   end

   assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_shadow_reg_bank.sv
// Scoreboard bench for shadow_reg_bank: directed frame-boundary scenarios plus random traffic.
module tb_shadow_reg_bank;

   localparam int N = 4;
   localparam int W = 32;
   localparam int G = 64;

   typedef struct packed {
      logic [N-1:0] dirty;
      logic [7:0]   missed;
      logic         pulse;
   } status_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           wr_en, wr_lock, vblank_start, missed_clr;
   logic [1:0]     wr_idx;
   logic [W-1:0]   wr_data;
   logic [W/8-1:0] wr_be;
   logic [N*W-1:0] active_regs;
   logic [N-1:0]   dirty;
   logic           commit_pulse;
   logic [7:0]     missed_cnt;
`ifdef SHADOW_READBACK_EN
   logic [1:0]     rd_idx = '0;
   logic [W-1:0]   rd_data;
`endif

   shadow_reg_bank #(
      .N_REGS (N),
      .WIDTH  (W),
      .GRACE  (G)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wr_idx       (wr_idx),
      .wr_data      (wr_data),
      .wr_be        (wr_be),
      .wr_lock      (wr_lock),
      .vblank_start (vblank_start),
`ifdef SHADOW_READBACK_EN
      .rd_idx       (rd_idx),
      .rd_data      (rd_data),
`endif
      .active_regs  (active_regs),
      .dirty        (dirty),
      .commit_pulse (commit_pulse),
      .missed_cnt   (missed_cnt),
      .missed_clr   (missed_clr)
   );

   always #5 clk = ~clk;

   // Reference model: what the PPU should see, tracked as plain arrays.
   logic [W-1:0]   m_shadow [N];
   logic [W-1:0]   m_active [N];
   bit             m_dirty  [N];
   bit             m_pending;
   int             m_grace;
   int             m_missed;

   status_t        stat_q[$];
   logic [N*W-1:0] commit_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_shadow[i] = '0;
         m_active[i] = '0;
         m_dirty[i]  = 1'b0;
      end
      m_pending = 1'b0;
      m_grace   = 0;
      m_missed  = 0;
   endtask

   task automatic model_step();
      bit             do_commit = 1'b0;
      bit             do_miss   = 1'b0;
      bit             any_dirty = 1'b0;
      status_t        s;
      logic [N*W-1:0] snap;
      for (int i = 0; i < N; i++) any_dirty |= m_dirty[i];
      if (m_pending) begin
         if (!wr_lock)          do_commit = 1'b1;
         else if (m_grace == 0) begin do_miss = 1'b1; m_pending = 1'b0; end
         else                   m_grace--;
      end else if (vblank_start && any_dirty) begin
         if (wr_lock) begin m_pending = 1'b1; m_grace = G - 1; end
         else do_commit = 1'b1;
      end
      if (do_commit) begin
         for (int i = 0; i < N; i++) begin
            if (m_dirty[i]) begin
               m_active[i] = m_shadow[i];
               m_dirty[i]  = 1'b0;
            end
         end
         m_pending = 1'b0;
      end
      if (wr_en && (wr_be != '0)) begin
         for (int b = 0; b < W/8; b++)
            if (wr_be[b]) m_shadow[wr_idx][b*8 +: 8] = wr_data[b*8 +: 8];
         m_dirty[wr_idx] = 1'b1;
      end
      if (missed_clr) m_missed = 0;
      else if (do_miss && m_missed < 255) m_missed++;
      for (int i = 0; i < N; i++) begin
         snap[i*W +: W] = m_active[i];
         s.dirty[i]     = m_dirty[i];
      end
      s.missed = 8'(m_missed);
      s.pulse  = do_commit;
      if (do_commit) commit_q.push_back(snap);
      stat_q.push_back(s);
   endtask

   task automatic cyc(input bit en, input int idx, input logic [W-1:0] data, input logic [3:0] be,
                      input bit lock, input bit vb, input bit clr);
      @(negedge clk);
      wr_en        = en;
      wr_idx       = idx[1:0];
      wr_data      = data;
      wr_be        = be;
      wr_lock      = lock;
      vblank_start = vb;
      missed_clr   = clr;
      @(posedge clk);
      model_step();
   endtask

   // Monitor: per-cycle status against the model, active copies on each commit pulse.
   initial begin
      status_t        s;
      logic [N*W-1:0] exp_active;
      forever begin
         @(negedge clk);
         if (stat_q.size() > 0) begin
            s = stat_q.pop_front();
            check("dirty", dirty, s.dirty);
            check("missed_cnt", missed_cnt, s.missed);
            check("commit_pulse", commit_pulse, s.pulse);
         end
         if (commit_pulse === 1'b1) begin
            if (commit_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_commit: got active=%h expected no commit", active_regs);
            end else begin
               exp_active = commit_q.pop_front();
               $display("commit @%0t active=%h", $time, active_regs);
               check("active_regs", active_regs, exp_active);
            end
         end
      end
   end

   initial begin
      bit lock_r = 1'b0;
      rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; wr_be = '0;
      wr_lock = 1'b0; vblank_start = 1'b0; missed_clr = 1'b0;
      model_reset();
      #1;
      check("reset_active", active_regs, '0);
      check("reset_dirty", dirty, '0);
      check("reset_missed", missed_cnt, '0);
      check("reset_pulse", commit_pulse, '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Full-word write then commit at vblank
      cyc(1, 1, 32'h12345678, 4'hF, 0, 0, 0);
      cyc(0, 0, '0, 4'h0, 0, 1, 0);
      #1 check("t1_active1", active_regs[63:32], 32'h12345678);
      check("t1_dirty", dirty, 4'b0000);

      // Byte-enable merge
      cyc(1, 0, 32'hAABBCCDD, 4'hF, 0, 0, 0);
      cyc(0, 0, '0, 4'h0, 0, 1, 0);
      cyc(1, 0, 32'h11223344, 4'b0101, 0, 0, 0);
      cyc(0, 0, '0, 4'h0, 0, 1, 0);
      #1 check("t2_byte_merge", active_regs[31:0], 32'hAA22CC44);

      // Lock released within the grace window
      cyc(1, 3, 32'hCAFEF00D, 4'hF, 0, 0, 0);
      cyc(0, 0, '0, 4'h0, 1, 1, 0);
      repeat (10) cyc(0, 0, '0, 4'h0, 1, 0, 0);
      #1 check("t3_held", active_regs[127:96], 32'h0);
      cyc(0, 0, '0, 4'h0, 0, 0, 0);
      #1 check("t3_release_commit", active_regs[127:96], 32'hCAFEF00D);
      check("t3_pulse", commit_pulse, 1'b1);
      check("t3_missed", missed_cnt, 8'd0);

      // Lock held past the grace window
      cyc(1, 3, 32'h0BADBEEF, 4'hF, 0, 0, 0);
      cyc(0, 0, '0, 4'h0, 1, 1, 0);
      repeat (70) cyc(0, 0, '0, 4'h0, 1, 0, 0);
      #1 check("t4_missed", missed_cnt, 8'd1);
      check("t4_no_commit", active_regs[127:96], 32'hCAFEF00D);
      check("t4_dirty", dirty, 4'b1000);
      cyc(0, 0, '0, 4'h0, 0, 0, 0);
      #1 check("t4_no_late_commit", active_regs[127:96], 32'hCAFEF00D);
      cyc(0, 0, '0, 4'h0, 0, 1, 0);
      #1 check("t4_next_vblank", active_regs[127:96], 32'h0BADBEEF);

      // Write in the commit cycle
      cyc(1, 2, 32'h11111111, 4'hF, 0, 0, 0);
      cyc(1, 2, 32'h22222222, 4'hF, 0, 1, 0);
      #1 check("t5_old_value", active_regs[95:64], 32'h11111111);
      check("t5_dirty2", dirty, 4'b0100);
      cyc(0, 0, '0, 4'h0, 0, 1, 0);
      #1 check("t5_new_value", active_regs[95:64], 32'h22222222);

      // Asynchronous reset while a commit is held
      cyc(1, 1, 32'h55555555, 4'hF, 0, 0, 0);
      cyc(0, 0, '0, 4'h0, 1, 1, 0);
      repeat (3) cyc(0, 0, '0, 4'h0, 1, 0, 0);
      @(negedge clk);
      wr_lock = 1'b0;
      #2 rst_n = 1'b0;
      #1 check("t6_active", active_regs, '0);
      check("t6_dirty", dirty, '0);
      check("t6_missed", missed_cnt, '0);
      check("t6_pulse", commit_pulse, 1'b0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) cyc(0, 0, '0, 4'h0, 0, 1, 0);
      #1 check("t6_after_release", active_regs, '0);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         if (lock_r) lock_r = ($urandom_range(29) != 0);
         else        lock_r = ($urandom_range(59) == 0);
         cyc($urandom_range(2) == 0, int'($urandom_range(N - 1)), $urandom, 4'($urandom),
             lock_r, $urandom_range(49) == 0, $urandom_range(199) == 0);
      end
      cyc(0, 0, '0, 4'h0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      check("commit_q_drained", 128'(commit_q.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
